// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types for the PLL lock sequencer: FSM state encoding and retry counter width.
package pll_lock_sequencer_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

endpackage

// File: rtl/pll_lock_sequencer_sync2.sv
// Two-flop synchroniser for a single asynchronous status bit; clears to 0 on reset.
module pll_lock_sequencer_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL RESETB, waits for lock with timeout/retry, gates design reset.
// Optional macro PLL_BYPASS_FAIL_EN: in FAIL, bypass the PLL and release design reset after RST_CYCLES.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 17
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pll_lock,
  output logic               pll_resetb,
  output logic               pll_bypass,
  output logic               design_reset,
  output logic               locked,
  output logic               failed,
  output logic [RETRY_W-1:0] retry_count,
  output logic               lock_lost
);

  localparam logic [CNT_W-1:0]   RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  logic               w_lockSync;
  state_e             r_state;
  state_e             w_stateNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [RETRY_W-1:0] r_retryCount;
  logic [RETRY_W-1:0] w_retryNext;
  logic [RETRY_W-1:0] w_retryInc;
  logic               w_lostNext;
  logic               w_pllResetbNext;
  logic               w_designResetNext;
  logic               r_pllResetb;
  logic               r_designReset;
  logic               r_locked;
  logic               r_failed;
  logic               r_lockLost;

  pll_lock_sequencer_sync2 u_lockSync (
    .clock   (clock),
    .reset   (reset),
    .i_async (pll_lock),
    .o_sync  (w_lockSync)
  );

  // Single down-counter, reloaded on every state entry; lock beats timeout on the cnt==0 cycle.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_retryNext = r_retryCount;
    w_lostNext  = 1'b0;
    w_retryInc  = r_retryCount + RETRY_W'(1);
    case (r_state)
      PLL_RST: begin
        if (r_cnt == '0) begin
          w_stateNext = WAIT_LOCK;
          w_cntNext   = TIMEOUT_LOAD;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (w_lockSync) begin
          w_stateNext = SETTLE;
          w_cntNext   = SETTLE_LOAD;
        end else if (r_cnt == '0) begin
          w_retryNext = w_retryInc;
          w_cntNext   = RST_LOAD;
          w_stateNext = (w_retryInc == RETRY_MAX) ? FAIL : PLL_RST;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (!w_lockSync) begin
          w_stateNext = WAIT_LOCK;
          w_cntNext   = TIMEOUT_LOAD;
        end else if (r_cnt == '0) begin
          w_stateNext = RUN;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      RUN: begin
        if (!w_lockSync) begin
          w_stateNext = PLL_RST;
          w_cntNext   = RST_LOAD;
          w_retryNext = '0;
          w_lostNext  = 1'b1;
        end
      end
      FAIL: begin
        if (r_cnt != '0) begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = PLL_RST;
        w_cntNext   = RST_LOAD;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so outputs track the state register.
  always_comb begin
    w_pllResetbNext   = (w_stateNext != PLL_RST);
    w_designResetNext = (w_stateNext != RUN);
`ifdef PLL_BYPASS_FAIL_EN
    if (w_stateNext == FAIL) begin
      w_pllResetbNext = 1'b0;
    end
    if ((r_state == FAIL) && (r_cnt == '0)) begin
      w_designResetNext = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= PLL_RST;
      r_cnt         <= RST_LOAD;
      r_retryCount  <= '0;
      r_pllResetb   <= 1'b0;
      r_designReset <= 1'b1;
      r_locked      <= 1'b0;
      r_failed      <= 1'b0;
      r_lockLost    <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_cnt         <= w_cntNext;
      r_retryCount  <= w_retryNext;
      r_pllResetb   <= w_pllResetbNext;
      r_designReset <= w_designResetNext;
      r_locked      <= (w_stateNext == RUN);
      r_failed      <= (w_stateNext == FAIL);
      r_lockLost    <= w_lostNext;
    end
  end

`ifdef PLL_BYPASS_FAIL_EN
  logic r_pllBypass;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pllBypass <= 1'b0;
    end else begin
      r_pllBypass <= (w_stateNext == FAIL);
    end
  end

  assign pll_bypass = r_pllBypass;
`else
  assign pll_bypass = 1'b0;
`endif

  assign pll_resetb   = r_pllResetb;
  assign design_reset = r_designReset;
  assign locked       = r_locked;
  assign failed       = r_failed;
  assign retry_count  = r_retryCount;
  assign lock_lost    = r_lockLost;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer; honours PLL_BYPASS_FAIL_EN for the FAIL checks.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int SETTLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  localparam int CNT_W         = 17;
  localparam int LIMIT         = 200;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       design_reset;
  logic       locked;
  logic       failed;
  logic [3:0] retry_count;
  logic       lock_lost;

  int errors = 0;
  int checks = 0;
  int n;
  int lostSeen;

  always #5 clock = ~clock;

  pll_lock_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY),
    .CNT_W         (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .pll_resetb   (pll_resetb),
    .pll_bypass   (pll_bypass),
    .design_reset (design_reset),
    .locked       (locked),
    .failed       (failed),
    .retry_count  (retry_count),
    .lock_lost    (lock_lost)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic lockValue, input int cycles);
    pll_lock = lockValue;
    repeat (cycles) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset    = 1'b1;
    pll_lock = 1'b0;
    repeat (2) tick();

    $display("[TB] reset state");
    checkOutput("rst_pll_resetb", 32'(pll_resetb), 0);
    checkOutput("rst_design_reset", 32'(design_reset), 1);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_failed", 32'(failed), 0);
    checkOutput("rst_retry", 32'(retry_count), 0);
    checkOutput("rst_lock_lost", 32'(lock_lost), 0);
    checkOutput("rst_bypass", 32'(pll_bypass), 0);

    // First attempt: lock never comes, timeout after 4 reset + 32 wait cycles.
    $display("[TB] first attempt times out");
    reset = 1'b0;
    n = 0;
    while (pll_resetb !== 1'b1 && n < LIMIT) begin tick(); n++; end
    checkOutput("rst_low_cycles_1", 32'(n), 4);
    while (retry_count === 4'd0 && n < LIMIT) begin tick(); n++; end
    checkOutput("timeout_cycles_1", 32'(n), 36);
    checkOutput("timeout_retry_1", 32'(retry_count), 1);
    checkOutput("timeout_back_to_rst", 32'(pll_resetb), 0);
    checkOutput("timeout_failed", 32'(failed), 0);
    checkOutput("timeout_design_reset", 32'(design_reset), 1);

    // Second attempt: lock arrives 10 cycles after RESETB release; 2 sync + 8 settle + 1 register.
    $display("[TB] second attempt locks");
    n = 0;
    while (pll_resetb !== 1'b1 && n < LIMIT) begin tick(); n++; end
    checkOutput("rst_low_cycles_2", 32'(n), 4);
    applyStimulus(1'b0, 10);
    pll_lock = 1'b1;
    n = 0;
    while (design_reset !== 1'b0 && n < LIMIT) begin tick(); n++; end
    checkOutput("settle_latency", 32'(n), 11);
    checkOutput("run_locked", 32'(locked), 1);
    checkOutput("run_retry_kept", 32'(retry_count), 1);
    checkOutput("run_failed", 32'(failed), 0);
    checkOutput("run_pll_resetb", 32'(pll_resetb), 1);

    // Lock loss in RUN: decision lands 3 cycles after the drop.
    $display("[TB] lock loss in RUN");
    applyStimulus(1'b0, 2);
    checkOutput("drop_still_locked", 32'(locked), 1);
    checkOutput("drop_no_pulse_yet", 32'(lock_lost), 0);
    tick();
    checkOutput("drop_lock_lost", 32'(lock_lost), 1);
    checkOutput("drop_locked", 32'(locked), 0);
    checkOutput("drop_pll_resetb", 32'(pll_resetb), 0);
    checkOutput("drop_retry_cleared", 32'(retry_count), 0);
    lostSeen = 0;
    n = 0;
    while (pll_resetb !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
      if (lock_lost === 1'b1) lostSeen++;
    end
    checkOutput("drop_rst_low_cycles", 32'(n), 4);
    checkOutput("lock_lost_single", 32'(lostSeen), 0);
    checkOutput("drop_design_reset", 32'(design_reset), 1);

    // Relock with a 3-cycle glitch inside SETTLE: settle must restart in full.
    $display("[TB] settle glitch");
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 3);
    pll_lock = 1'b1;
    n = 0;
    while (design_reset !== 1'b0 && n < LIMIT) begin tick(); n++; end
    checkOutput("glitch_resettle", 32'(n), 11);
    checkOutput("glitch_retry", 32'(retry_count), 0);
    checkOutput("glitch_locked", 32'(locked), 1);

    // Asynchronous reset in the middle of SETTLE with a non-zero retry count.
    $display("[TB] reset mid-settle");
    reset = 1'b1;
    pll_lock = 1'b0;
    tick();
    reset = 1'b0;
    n = 0;
    while (retry_count === 4'd0 && n < LIMIT) begin tick(); n++; end
    n = 0;
    while (pll_resetb !== 1'b1 && n < LIMIT) begin tick(); n++; end
    applyStimulus(1'b1, 5);
    checkOutput("mid_settle_retry", 32'(retry_count), 1);
    checkOutput("mid_settle_resetb", 32'(pll_resetb), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_pll_resetb", 32'(pll_resetb), 0);
    checkOutput("async_design_reset", 32'(design_reset), 1);
    checkOutput("async_retry", 32'(retry_count), 0);
    checkOutput("async_locked", 32'(locked), 0);

    // Lock held low: two timeouts exhaust the retry budget.
    $display("[TB] retries exhausted");
    pll_lock = 1'b0;
    tick();
    reset = 1'b0;
    n = 0;
    while (failed !== 1'b1 && n < LIMIT) begin tick(); n++; end
    checkOutput("fail_cycles", 32'(n), 72);
    checkOutput("fail_retry", 32'(retry_count), 2);
    checkOutput("fail_locked", 32'(locked), 0);
    checkOutput("fail_design_reset", 32'(design_reset), 1);
`ifdef PLL_BYPASS_FAIL_EN
    checkOutput("fail_bypass", 32'(pll_bypass), 1);
    checkOutput("fail_pll_resetb", 32'(pll_resetb), 0);
    n = 0;
    while (design_reset !== 1'b0 && n < LIMIT) begin tick(); n++; end
    checkOutput("bypass_release_cycles", 32'(n), 4);
    checkOutput("bypass_failed", 32'(failed), 1);
    checkOutput("bypass_locked", 32'(locked), 0);
`else
    applyStimulus(1'b0, 20);
    checkOutput("fail_hold_design_reset", 32'(design_reset), 1);
    checkOutput("fail_hold_failed", 32'(failed), 1);
    checkOutput("fail_hold_retry", 32'(retry_count), 2);
    checkOutput("fail_hold_bypass", 32'(pll_bypass), 0);
    checkOutput("fail_hold_pll_resetb", 32'(pll_resetb), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
